// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver:
// active-low segment table, all-off pattern and scan FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG7_OFF = 7'h7F;

    // Index is the hex digit; bits are {g,f,e,d,c,b,a}, 0 = segment lit.
    localparam logic [6:0] SEG7_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        BLANK,
        DRIVE
    } scan_state_e;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG7_HEX[nibble_i];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver: one digit per rising edge of the scan
// clock, with an all-off blanking gap and optional leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned LZ_BLANK     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clk_500Hz,
    input  logic [4*NUM_DIGITS-1:0]       value,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

    localparam int unsigned IdxW = $clog2(NUM_DIGITS);
    localparam int unsigned CntW = $clog2(BLANK_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NUM_DIGITS - 1);

    scan_state_e             state_q, state_d;
    logic                    prev_scan_q;
    logic [CntW-1:0]         blank_cnt_q, blank_cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;

    logic                    tick;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_en;
    logic                    upper_zero;
    logic                    lz_flag;
    logic [NUM_DIGITS-1:0]   idx_onehot;
    logic [6:0]              cur_seg;

    // Select the current digit's inputs; upper_zero covers nibbles idx..top.
    always_comb begin
        cur_nib    = '0;
        cur_dp     = 1'b0;
        cur_en     = 1'b0;
        upper_zero = 1'b1;
        idx_onehot = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_nib       = value[4*i +: 4];
                cur_dp        = dp_in[i];
                cur_en        = digit_en[i];
                idx_onehot[i] = 1'b1;
            end
            if (IdxW'(i) >= idx_q && value[4*i +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        lz_flag = (LZ_BLANK == 1) && (idx_q != '0) && !cur_dp && upper_zero;
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (cur_nib),
        .seg_o    (cur_seg)
    );

    assign tick = clk_500Hz & ~prev_scan_q;

    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        idx_d       = idx_q;
        an_d        = an_q;
        seg_d       = seg_q;
        dp_d        = dp_q;

        if (tick) begin
            // A tick always wins so no scan edge is ever dropped.
            idx_d       = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
            blank_cnt_d = '0;
            state_d     = BLANK;
            an_d        = '1;
            seg_d       = SEG7_OFF;
            dp_d        = 1'b1;
        end else begin
            unique case (state_q)
                BLANK: begin
                    if (blank_cnt_q == CntLast) begin
                        // The output registers act as the slot's shadow latch.
                        state_d     = DRIVE;
                        blank_cnt_d = '0;
                        an_d        = (cur_en && !lz_flag) ? ~idx_onehot : '1;
                        seg_d       = cur_seg;
                        dp_d        = ~cur_dp;
                    end else begin
                        blank_cnt_d = blank_cnt_q + 1'b1;
                    end
                end
                DRIVE: begin
                    state_d = DRIVE;
                end
                default: begin
                    state_d = BLANK;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BLANK;
            prev_scan_q <= 1'b0;
            blank_cnt_q <= '0;
            idx_q       <= '0;
            an_q        <= '1;
            seg_q       <= SEG7_OFF;
            dp_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            prev_scan_q <= clk_500Hz;
            blank_cnt_q <= blank_cnt_d;
            idx_q       <= idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digit_idx = idx_q;

endmodule
